// File: rtl/simple_spi_pkg.sv
// Shared constants, clock-divisor lookup and shift-engine states for the
// APB-attached SPI master.
package simple_spi_pkg;

  localparam logic [1:0] ADDR_SPCR = 2'd0;
  localparam logic [1:0] ADDR_SPSR = 2'd1;
  localparam logic [1:0] ADDR_SPDR = 2'd2;
  localparam logic [1:0] ADDR_SPER = 2'd3;

  localparam logic [7:0] SPCR_RST  = 8'h10;
  localparam logic [7:0] SPCR_MASK = 8'hDF;
  localparam logic [7:0] SPER_RST  = 8'h00;

  localparam int PRESC_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PHASE1 = 2'd1,
    ST_PHASE2 = 2'd2
  } eng_state_t;

  // Half the SCK period minus one, indexed by {ESPR,SPR}.
  function automatic logic [PRESC_W-1:0] div_half_m1(input logic [3:0] code);
    case (code)
      4'd0:    return 11'd0;
      4'd1:    return 11'd1;
      4'd2:    return 11'd7;
      4'd3:    return 11'd15;
      4'd4:    return 11'd3;
      4'd5:    return 11'd31;
      4'd6:    return 11'd63;
      4'd7:    return 11'd127;
      4'd8:    return 11'd255;
      4'd9:    return 11'd511;
      4'd10:   return 11'd1023;
      default: return 11'd2047;
    endcase
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// Small synchronous FIFO; dout shows the head entry, clr flushes it.
// A pop frees a slot in time for a push in the same cycle.
module spi_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wp;
  logic [AW:0]       rp;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/simple_spi_apb.sv
// APB slave wrapping an MC68HC11-style SPI master: register file and FIFOs
// in front, a byte-serial shift engine behind.
module simple_spi_apb
  import simple_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [7:0] PADDR,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PSLAVERR,
  output logic       INTR_0,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  logic       clk;
  logic       rst;
  logic       acc, wr, rd;
  logic [1:0] addr;
  logic       unused_addr;
  logic [7:0] spcr;
  logic       spie, spe, mstr, cpol, cpha;
  logic [1:0] spr, icnt, espr, tcnt;
  logic       spif, wcol;
  logic [7:0] spsr, rd_data, last_head;
  logic       wf_push, wf_pop, wf_full, wf_empty;
  logic [7:0] wf_dout;
  logic       rf_pop, rf_full, rf_empty;
  logic [7:0] rf_dout, rx_byte;
  eng_state_t state, state_nx;
  logic       tick, start, lead, trail, done;
  logic [PRESC_W-1:0] pcnt;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       miso_q, rx_bit;

  assign clk = PCLK;
  assign rst = PRESETn;  // active-high despite the legacy name

  assign acc         = PSEL & PENABLE;
  assign wr          = acc & PWRITE;
  assign rd          = acc & ~PWRITE;
  assign addr        = PADDR[1:0];
  assign unused_addr = ^PADDR[7:2];

  assign spie = spcr[7];
  assign spe  = spcr[6];
  assign mstr = spcr[4];
  assign cpol = spcr[3];
  assign cpha = spcr[2];
  assign spr  = spcr[1:0];

  assign PSLAVERR = 1'b0;
  assign INTR_0   = spif & spie;

  assign wf_push = wr && (addr == ADDR_SPDR);
  assign wf_pop  = start;
  assign rf_pop  = rd && (addr == ADDR_SPDR) && !rf_empty;
  assign spsr    = {spif, wcol, 2'b00, wf_full, wf_empty, rf_full, rf_empty};

  // CPHA=0 samples on the leading edge into miso_q; CPHA=1 samples live on the trailing edge.
  assign rx_bit  = cpha ? miso_i : miso_q;
  assign rx_byte = {shreg[6:0], rx_bit};
  assign tick    = (pcnt == '0);

  spi_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_wfifo (
    .clk(clk), .rst(rst), .clr(~spe), .push(wf_push), .pop(wf_pop),
    .din(PWDATA), .dout(wf_dout), .full(wf_full), .empty(wf_empty)
  );

  spi_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_rfifo (
    .clk(clk), .rst(rst), .clr(~spe), .push(done), .pop(rf_pop),
    .din(rx_byte), .dout(rf_dout), .full(rf_full), .empty(rf_empty)
  );

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_SPCR: rd_data = spcr;
      ADDR_SPSR: rd_data = spsr;
      ADDR_SPDR: rd_data = rf_empty ? last_head : rf_dout;
      default:   rd_data = {icnt, 4'b0000, espr};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spcr      <= SPCR_RST;
      icnt      <= SPER_RST[7:6];
      espr      <= SPER_RST[1:0];
      spif      <= 1'b0;
      wcol      <= 1'b0;
      tcnt      <= 2'd0;
      PRDATA    <= 8'h00;
      last_head <= 8'h00;
    end else begin
      if (wr && addr == ADDR_SPCR) spcr <= PWDATA & SPCR_MASK;
      if (wr && addr == ADDR_SPER) begin
        icnt <= PWDATA[7:6];
        espr <= PWDATA[1:0];
      end
      // A completion setting SPIF wins over a software clear in the same cycle.
      if (done && tcnt == icnt)                         spif <= 1'b1;
      else if (wr && addr == ADDR_SPSR && PWDATA[7])    spif <= 1'b0;
      if (wf_push && wf_full && !wf_pop)                wcol <= 1'b1;
      else if (wr && addr == ADDR_SPSR && PWDATA[6])    wcol <= 1'b0;
      if (!spe || (wr && addr == ADDR_SPER))            tcnt <= 2'd0;
      else if (done)                                    tcnt <= (tcnt == icnt) ? 2'd0 : tcnt + 2'd1;
      if (rd)     PRDATA    <= rd_data;
      if (rf_pop) last_head <= rf_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    lead     = 1'b0;
    trail    = 1'b0;
    done     = 1'b0;
    if (!spe) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mstr && !wf_empty) begin
            start    = 1'b1;
            state_nx = ST_PHASE1;
          end
        end
        ST_PHASE1: begin
          if (tick) begin
            lead     = 1'b1;
            state_nx = ST_PHASE2;
          end
        end
        ST_PHASE2: begin
          if (tick) begin
            trail = 1'b1;
            if (bitcnt == 3'd0) begin
              done     = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_PHASE1;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      bitcnt <= 3'd0;
      sck_o  <= 1'b0;
      mosi_o <= 1'b0;
    end else begin
      pcnt <= (state == ST_IDLE || tick) ? div_half_m1({espr, spr}) : pcnt - 1'b1;
      if (!spe || state == ST_IDLE) sck_o <= cpol;
      else if (lead || trail)       sck_o <= ~sck_o;
      if (start)                          bitcnt <= 3'd7;
      else if (trail && bitcnt != 3'd0)   bitcnt <= bitcnt - 3'd1;
      if (start && !cpha)       mosi_o <= wf_dout[7];
      else if (lead && cpha)    mosi_o <= shreg[7];
      else if (trail && !cpha)  mosi_o <= shreg[6];
    end
  end

  always_ff @(posedge clk) begin
    if (start)      shreg <= wf_dout;
    else if (trail) shreg <= rx_byte;
    if (lead) miso_q <= miso_i;
  end

endmodule

// File: tb/tb_simple_spi_apb.sv
// Directed and randomized bench for simple_spi_apb with mosi looped to miso;
// expectations come from a queue-based register/FIFO model.
module tb_simple_spi_apb;

  localparam int DEPTH = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn, PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PSLAVERR, INTR_0, sck_o, mosi_o, miso_i;

  int checks = 0;
  int errors = 0;

  simple_spi_apb #(.FIFO_DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PSLAVERR(PSLAVERR), .INTR_0(INTR_0), .sck_o(sck_o), .mosi_o(mosi_o),
    .miso_i(miso_i)
  );

  assign miso_i = mosi_o;
  always #5 PCLK = ~PCLK;

  int div_tab [16] = '{2, 4, 16, 32, 8, 64, 128, 256, 512, 1024, 2048, 4096,
                       4096, 4096, 4096, 4096};

  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] m_spcr, m_last;
  logic [1:0] m_icnt, m_espr;
  logic       m_spif, m_wcol;
  int         m_since;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_spsr();
    return {m_spif, m_wcol, 2'b00, wq.size() == DEPTH, wq.size() == 0,
            rq.size() == DEPTH, rq.size() == 0};
  endfunction

  function automatic void m_flush();
    wq.delete();
    rq.delete();
    m_since = 0;
  endfunction

  // Every queued byte comes back unchanged through the loopback.
  function automatic void m_run();
    logic [7:0] b;
    while (wq.size() > 0 && m_spcr[6] && m_spcr[4]) begin
      b = wq.pop_front();
      if (rq.size() < DEPTH) rq.push_back(b);
      m_since++;
      if (m_since == int'(m_icnt) + 1) begin
        m_spif  = 1'b1;
        m_since = 0;
      end
    end
  endfunction

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK); PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK); PSEL = 0; PENABLE = 0; d = PRDATA;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    apb_write({6'($urandom), a}, d);
    case (a)
      2'd0: begin m_spcr = d & 8'hDF; if (!m_spcr[6]) m_flush(); end
      2'd1: begin if (d[7]) m_spif = 1'b0; if (d[6]) m_wcol = 1'b0; end
      2'd2: if (m_spcr[6]) begin
              if (wq.size() < DEPTH) wq.push_back(d);
              else m_wcol = 1'b1;
            end
      default: begin m_icnt = d[7:6]; m_espr = d[1:0]; m_since = 0; end
    endcase
  endtask

  task automatic reg_check(input logic [1:0] a, input string tag);
    logic [7:0] exp, got;
    case (a)
      2'd0: exp = m_spcr;
      2'd1: exp = m_spsr();
      2'd2: begin if (rq.size() > 0) m_last = rq.pop_front(); exp = m_last; end
      default: exp = {m_icnt, 4'b0000, m_espr};
    endcase
    apb_read({6'($urandom), a}, got);
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic xfer_wait(input int n);
    int d;
    d = div_tab[{m_espr, m_spcr[1:0]}];
    repeat (n * (8 * d + 4) + 10) @(posedge PCLK);
    @(negedge PCLK);
    m_run();
  endtask

  task automatic measure(input logic [3:0] code, input string tag);
    int t[3];
    int edges, cyc;
    logic prev;
    reg_write(2'd3, {6'b000000, code[3:2]});
    reg_write(2'd0, {6'b010100, code[1:0]});
    reg_write(2'd2, 8'h5A);
    prev = sck_o; edges = 0; cyc = 0;
    while (edges < 3 && cyc < 3 * div_tab[code] + 200) begin
      @(negedge PCLK); cyc++;
      if (sck_o !== prev) begin t[edges] = cyc; edges++; prev = sck_o; end
    end
    if (edges == 3) check(tag, 32'(t[2] - t[0]), 32'(div_tab[code]));
    else check({tag, "_timeout"}, 32'(edges), 32'd3);
    reg_write(2'd0, 8'h00);
    reg_write(2'd3, 8'h00);
  endtask

  initial begin
    logic [7:0] ctl;
    int n, nr;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PRESETn = 1;
    m_spcr = 8'h10; m_icnt = 0; m_espr = 0; m_spif = 0; m_wcol = 0; m_since = 0; m_last = 0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK); PRESETn = 0;
    @(negedge PCLK);

    check("rst_intr", 32'(INTR_0), 32'd0);
    check("rst_pslverr", 32'(PSLAVERR), 32'd0);
    check("rst_sck", 32'(sck_o), 32'd0);
    check("rst_mosi", 32'(mosi_o), 32'd0);
    reg_check(2'd0, "rst_spcr");
    reg_check(2'd1, "rst_spsr");
    reg_check(2'd2, "rst_spdr");
    reg_check(2'd3, "rst_sper");

    // single-byte loopback with interrupt
    reg_write(2'd0, 8'hD0);
    reg_write(2'd2, 8'hA5);
    xfer_wait(1);
    reg_check(2'd1, "lb_spsr_pre");
    check("lb_intr", 32'(INTR_0), 32'd1);
    reg_check(2'd2, "lb_spdr");
    check("lb_spdr_val", 32'(m_last), 32'hA5);
    reg_check(2'd1, "lb_spsr_post");
    reg_write(2'd1, 8'h80);
    check("lb_intr_clr", 32'(INTR_0), 32'd0);

    for (int m = 0; m < 4; m++) begin
      reg_write(2'd0, 8'h50 | 8'(m << 2));
      reg_write(2'd2, 8'h3C);
      xfer_wait(1);
      check($sformatf("mode%0d_sck_idle", m), 32'(sck_o), 32'(m_spcr[3]));
      reg_check(2'd2, $sformatf("mode%0d_data", m));
      reg_write(2'd1, 8'hC0);
    end

    measure(4'd3, "div32");
    measure(4'd10, "div2048");
    measure(4'd11, "div4096");

    // write-FIFO overflow, then read-FIFO overflow
    reg_write(2'd1, 8'hC0);
    reg_write(2'd0, 8'h40);
    for (int i = 0; i < 5; i++) reg_write(2'd2, 8'($urandom));
    reg_check(2'd1, "ovf_wfull_wcol");
    reg_write(2'd0, 8'h50);
    xfer_wait(4);
    reg_check(2'd1, "ovf_rffull");
    reg_write(2'd2, 8'h77);
    xfer_wait(1);
    reg_check(2'd1, "ovf_drop_spsr");
    for (int i = 0; i < 4; i++) reg_check(2'd2, $sformatf("ovf_data%0d", i));
    reg_check(2'd2, "ovf_empty_read");
    reg_write(2'd1, 8'hC0);

    // SPIF after every fourth byte
    reg_write(2'd3, 8'hC0);
    reg_write(2'd0, 8'hD0);
    for (int b = 0; b < 4; b++) begin
      reg_write(2'd2, 8'($urandom));
      xfer_wait(1);
      reg_check(2'd1, $sformatf("icnt_spsr%0d", b));
      check($sformatf("icnt_intr%0d", b), 32'(INTR_0), 32'(m_spif & m_spcr[7]));
    end
    for (int b = 0; b < 4; b++) reg_check(2'd2, $sformatf("icnt_data%0d", b));
    reg_write(2'd1, 8'hC0);
    reg_write(2'd3, 8'h00);

    for (int it = 0; it < 8; it++) begin
      reg_write(2'd0, 8'h00);
      reg_write(2'd3, {2'($urandom), 6'b000000});
      ctl = {1'($urandom), 1'b1, 2'b00, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom)};
      reg_write(2'd0, ctl);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) reg_write(2'd2, 8'($urandom));
      reg_check(2'd1, $sformatf("rnd%0d_spsr_q", it));
      reg_write(2'd0, ctl | 8'h10);
      xfer_wait(n);
      check($sformatf("rnd%0d_sck_idle", it), 32'(sck_o), 32'(ctl[3]));
      reg_check(2'd1, $sformatf("rnd%0d_spsr_done", it));
      check($sformatf("rnd%0d_intr", it), 32'(INTR_0), 32'(m_spif & m_spcr[7]));
      nr = rq.size();
      for (int k = 0; k <= nr; k++) reg_check(2'd2, $sformatf("rnd%0d_data%0d", it, k));
      reg_write(2'd1, 8'hC0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
